pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_buf.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and its skid buffer.
// Holds the stage state encoding and the default datapath/control/counter widths.
// No logic; imported by every file of the stage.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // EMPTY: main register invalid; FULL: main valid, skid empty; SKID: both valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_buf.sv
// Skid holding register: captures one beat the main register cannot take while stalled.
// Latency: loaded beat visible on o_* the cycle after i_load.
// Backpressure: none of its own; the owning stage decides when to load and clear it.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Hold one beat; clear wins so a flush never leaves a stale beat behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ctrl <= '0;
        end else if (i_clear) begin
            r_vld  <= 1'b0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_ctrl <= i_ctrl;
        end
    end

    assign o_valid = r_vld;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with flush, masked control clearing and a saturating stall counter.
// Latency: 1 cycle from accepted beat to out_valid; out_data/out_ctrl held while stalled.
// Backpressure: PIPE_STAGE_SKID_EN defined -> skid beat + registered in_ready; else in_ready = !out_valid || out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W         = DATA_W_DEF,
    parameter int                CTRL_W         = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_KEEP_MASK = '0,
    parameter int                CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      r_state;
    logic              r_main_vld;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_accept;

    assign w_accept = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_in_rdy;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_vld;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    // A beat arriving while the main register is stalled parks in the skid buffer
    assign w_skid_load  = (r_state == ST_FULL) && w_accept && !out_ready && !flush;
    assign w_skid_clear = flush || ((r_state == ST_SKID) && out_ready);
    assign in_ready     = r_in_rdy;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_vld),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );
`else
    // Without a skid slot the stage can only accept when the main register frees up this cycle
    assign in_ready = !r_main_vld || out_ready;
`endif

    // Stage FSM and main output register; flush overrides every handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
            r_in_rdy    <= 1'b1;
`endif
        end else if (flush) begin
            // Held beat may still be consumed downstream this cycle; nothing survives the edge
            r_state     <= ST_EMPTY;
            r_main_vld  <= 1'b0;
            r_main_ctrl <= r_main_ctrl & CTRL_KEEP_MASK;
`ifdef PIPE_STAGE_SKID_EN
            r_in_rdy    <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_FULL;
                        r_main_vld  <= 1'b1;
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (out_ready && w_accept) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (out_ready) begin
                        // Drained with nothing behind it: unmasked control must read zero
                        r_state     <= ST_EMPTY;
                        r_main_vld  <= 1'b0;
                        r_main_ctrl <= r_main_ctrl & CTRL_KEEP_MASK;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (w_accept) begin
                        r_state  <= ST_SKID;
                        r_in_rdy <= 1'b0;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    // Older beat leaves, skid beat moves up on the same edge to keep order
                    if (out_ready) begin
                        r_state     <= ST_FULL;
                        r_main_data <= w_skid_data;
                        r_main_ctrl <= w_skid_ctrl;
                        r_in_rdy    <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state    <= ST_EMPTY;
                    r_main_vld <= 1'b0;
                end
            endcase
        end
    end

    // Count stalled cycles, sticking at all-ones; flush leaves the count alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_main_vld && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_main_vld;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table plus hand sequences, with an in-order beat scoreboard.
// Works with PIPE_STAGE_SKID_EN defined or not; only in_ready expectations differ.
// DUT built with CNT_W=4 and CTRL_KEEP_MASK=0x0001 so saturation and masking are reachable.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_ctrl;
    logic [3:0]  stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] ctrl;
    } beat_t;

    beat_t sb_q[$];
    logic  last_acc;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [15:0] c;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic [15:0] e_oc;
        logic [3:0]  e_st;
        logic        e_ir_comb;
        logic        e_ir_skid;
    } vec_t;

    vec_t vecs[6];

    pipe_stage_reg #(
        .DATA_W         (32),
        .CTRL_W         (16),
        .CTRL_KEEP_MASK (16'h0001),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
    endtask

    // Settle, score the handshakes of this cycle, then advance to the next negedge
    task automatic tick();
        beat_t b;
        #1;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: got beat 0x%0h, required no beat", out_data);
            end else begin
                b = sb_q.pop_front();
                chk("sb_data", out_data, b.data);
                chk("sb_ctrl", {16'h0, out_ctrl}, {16'h0, b.ctrl});
            end
        end
        last_acc = in_valid && in_ready && !flush;
        if (flush) begin
            sb_q.delete();
        end else if (last_acc) begin
            b.data = in_data;
            b.ctrl = in_ctrl;
            sb_q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        logic b_acc;
        logic e_ir;

        vecs[0] = '{1'b1, 32'h0000_1234, 16'h0003, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 16'h0003, 4'd0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_AAAA, 16'h00F0, 1'b1, 1'b0, 1'b1, 32'h0000_AAAA, 16'h00F0, 4'd0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 4'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_5555, 16'h0081, 1'b0, 1'b0, 1'b1, 32'h0000_5555, 16'h0081, 4'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_5555, 16'h0081, 4'd1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'h0001, 4'd1, 1'b1, 1'b1};

        // Reset state, checked before any clock edge
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data",  out_data, 32'h0);
        chk("rst_out_ctrl",  {16'h0, out_ctrl}, 32'h0);
        chk("rst_stall_cnt", {28'h0, stall_cnt}, 32'h0);
        chk("rst_in_ready",  {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: stream, drain, stall with masked control retention
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl);
            tick();
`ifdef PIPE_STAGE_SKID_EN
            e_ir = vecs[i].e_ir_skid;
`else
            e_ir = vecs[i].e_ir_comb;
`endif
            chk($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_ov});
            if (vecs[i].e_ov)
                chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("vec%0d_out_ctrl", i), {16'h0, out_ctrl}, {16'h0, vecs[i].e_oc});
            chk($sformatf("vec%0d_stall_cnt", i), {28'h0, stall_cnt}, {28'h0, vecs[i].e_st});
            chk($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, e_ir});
        end
        chk("vec_sb_drained", sb_q.size(), 32'd0);

        // Two beats offered under a 3-cycle stall, then released in order
        do_reset();
        drive(1'b1, 32'hA0A0_0001, 16'h0011, 1'b0, 1'b0);
        tick();
        chk("stall_a_out_data", out_data, 32'hA0A0_0001);
        b_acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(!b_acc, 32'hB0B0_0002, 16'h0022, 1'b0, 1'b0);
            tick();
            b_acc = b_acc | last_acc;
        end
        chk("stall_cnt_3",        {28'h0, stall_cnt}, 32'd3);
        chk("stall_in_ready",     {31'h0, in_ready}, 32'h0);
        chk("stall_a_held",       out_data, 32'hA0A0_0001);
        chk("stall_a_ctrl_held",  {16'h0, out_ctrl}, 32'h0011);
        drive(!b_acc, 32'hB0B0_0002, 16'h0022, 1'b1, 1'b0);
        tick();
        b_acc = b_acc | last_acc;
        chk("release_b_accepted", {31'h0, b_acc}, 32'h1);
        chk("release_out_valid",  {31'h0, out_valid}, 32'h1);
        chk("release_b_data",     out_data, 32'hB0B0_0002);
        chk("release_in_ready",   {31'h0, in_ready}, 32'h1);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("release_drained", {31'h0, out_valid}, 32'h0);
        chk("release_sb_drained", sb_q.size(), 32'd0);

        // Flush while stalled with a second beat pending; masked ctrl bit survives
        do_reset();
        drive(1'b1, 32'h0000_00A1, 16'h00FF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_00B2, 16'h00FF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_00C3, 16'h00FF, 1'b0, 1'b1);
        tick();
        chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_out_ctrl",  {16'h0, out_ctrl}, 32'h0001);
        chk("flush_in_ready",  {31'h0, in_ready}, 32'h1);
        chk("flush_stall_cnt", {28'h0, stall_cnt}, 32'd2);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("flush_no_emit", {31'h0, out_valid}, 32'h0);

        // Flush with out_ready=1: held beat still transfers, presented beat discarded
        drive(1'b1, 32'h0000_D00D, 16'h0002, 1'b1, 1'b0);
        tick();
        chk("flush2_d_loaded", out_data, 32'h0000_D00D);
        drive(1'b1, 32'h0000_E00E, 16'h0003, 1'b1, 1'b1);
        tick();
        chk("flush2_out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush2_out_ctrl",  {16'h0, out_ctrl}, 32'h0);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("flush2_no_emit", {31'h0, out_valid}, 32'h0);
        chk("flush2_sb_drained", sb_q.size(), 32'd0);

        // Stall counter saturates at 15 with a 4-bit counter
        do_reset();
        drive(1'b1, 32'h0000_5A5A, 16'h0004, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 22; k++) begin
            drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
            tick();
            if (k == 14) chk("sat_cnt_14", {28'h0, stall_cnt}, 32'd14);
            if (k == 15) chk("sat_cnt_15", {28'h0, stall_cnt}, 32'd15);
            if (k == 22) chk("sat_cnt_held", {28'h0, stall_cnt}, 32'd15);
        end
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("sat_drained", {31'h0, out_valid}, 32'h0);
        chk("sat_cnt_kept", {28'h0, stall_cnt}, 32'd15);

        // Asynchronous reset in the middle of a stall
        do_reset();
        drive(1'b1, 32'hCAFE_F00D, 16'h00F3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_BEEF, 16'h0005, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_out_data",  out_data, 32'h0);
        chk("arst_out_ctrl",  {16'h0, out_ctrl}, 32'h0);
        chk("arst_stall_cnt", {28'h0, stall_cnt}, 32'h0);
        chk("arst_in_ready",  {31'h0, in_ready}, 32'h1);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
            tick();
            chk($sformatf("arst_no_emit%0d", k), {31'h0, out_valid}, 32'h0);
        end
        drive(1'b1, 32'h0000_0F0F, 16'h0006, 1'b1, 1'b0);
        tick();
        chk("arst_first_accept", out_data, 32'h0000_0F0F);
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();

        // Backpressure visibility and back-to-back throughput
        drive(1'b1, 32'h7000_0000, 16'h0010, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h7000_0001, 16'h0011, 1'b0, 1'b0);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_in_ready_reg", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b0;
`else
        chk("bp_in_ready_comb", {31'h0, in_ready}, 32'h0);
`endif
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, 32'h7000_0000 + t, 16'h0010 + 16'(t), 1'b1, 1'b0);
            #1;
            chk($sformatf("thru%0d_in_ready", t), {31'h0, in_ready}, 32'h1);
            tick();
            chk($sformatf("thru%0d_out_valid", t), {31'h0, out_valid}, 32'h1);
            chk($sformatf("thru%0d_out_data", t), out_data, 32'h7000_0000 + t);
        end
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("thru_drained", {31'h0, out_valid}, 32'h0);
        chk("thru_sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_reg
